regfile_port_sched: RTL

- Upstream scheduler for the single-port 32x32 register file. The register file performs one read or one write per clock, selected by its r_or_w input.
- Accepts read requests from operand fetch and write-back requests from the execute/load path. Writes are queued in a small FIFO.
- Grants the register-file port once per cycle: reads have priority, with a write-starvation guard.
- Returns read data with 1-cycle latency and enforces read-after-write ordering against queued writes.

---
 rtl/regfile_port_sched_pkg.sv | 18 +
 rtl/regfile_port_sched_if.sv | 32 +++
 rtl/regfile_port_sched_wr_fifo.sv | 82 ++++++++
 rtl/regfile_port_sched.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/regfile_port_sched_pkg.sv
// Shared widths, queue entry payload and scheduler state for the register-file port scheduler.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_X0 = ADDR_W'(0);

    typedef enum logic {
        READ_PRI = 1'b0,
        FORCE_WR = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/regfile_port_sched_if.sv
// Request/response and register-file port bundle; slave = scheduler, master = clients + register file.
interface regfile_port_sched_if;
    import regfile_pkg::*;

    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_ready;
    logic              rd_rsp_valid;
    logic [DATA_W-1:0] rd_rsp_data;
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic              wr_req_ready;
    logic              rf_r_or_w;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_val;
    logic [DATA_W-1:0] rf_read_value;

    modport slave (
        input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, rf_read_value,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
               rf_r_or_w, rf_read_addr, rf_write_addr, rf_write_val
    );

    modport master (
        output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, rf_read_value,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready,
               rf_r_or_w, rf_read_addr, rf_write_addr, rf_write_val
    );

endinterface

// File: rtl/regfile_port_sched_wr_fifo.sv
// Circular write-back queue with per-entry address match and youngest-match data for forwarding.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned WQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_enq,
    input  wq_entry_t           i_enq_entry,
    input  logic                i_deq,
    input  logic [ADDR_W-1:0]   i_q_addr,
    output logic                o_full,
    output logic                o_empty,
    output wq_entry_t           o_head,
    output logic [WQ_DEPTH-1:0] o_match,
    output logic [DATA_W-1:0]   o_byp_data
);

    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wq_entry_t           r_mem [WQ_DEPTH];
    logic [WQ_DEPTH-1:0] r_vld;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [PTR_W-1:0]    w_idx;
    logic                w_enq_ok;
    logic                w_deq_ok;

    assign o_full   = (r_cnt == CNT_W'(WQ_DEPTH));
    assign o_empty  = (r_cnt == CNT_W'(0));
    assign o_head   = r_mem[r_rptr];
    assign w_enq_ok = i_enq && !o_full;
    assign w_deq_ok = i_deq && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_vld  <= '0;
        end else begin
            if (w_enq_ok) begin
                r_wptr        <= r_wptr + PTR_W'(1);
                r_vld[r_wptr] <= 1'b1;
            end
            if (w_deq_ok) begin
                r_rptr        <= r_rptr + PTR_W'(1);
                r_vld[r_rptr] <= 1'b0;
            end
            r_cnt <= r_cnt + CNT_W'(w_enq_ok) - CNT_W'(w_deq_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_ok) begin
            r_mem[r_wptr] <= i_enq_entry;
        end
    end

    always_comb begin
        o_match = '0;
        for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
            o_match[i] = r_vld[i] && (r_mem[i].addr == i_q_addr);
        end
    end

    // Walk oldest to youngest so the last hit is the most recent value.
    always_comb begin
        o_byp_data = '0;
        w_idx      = r_rptr;
        for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
            w_idx = r_rptr + PTR_W'(i);
            if (o_match[w_idx]) begin
                o_byp_data = r_mem[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_port_sched.sv
// Single-port register-file scheduler: read priority, starvation-bounded write queue, RAW ordering.
// Optional REGFILE_BYPASS_EN: hazard reads complete from the youngest queued write instead of stalling.
module regfile_port_sched
    import regfile_pkg::*;
#(
    parameter int unsigned WQ_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_port_sched_if.slave  bus
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    sched_state_e        r_state;
    sched_state_e        w_state_nxt;
    logic [STARVE_W-1:0] r_starve;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic                w_full;
    logic                w_empty;
    wq_entry_t           w_head;
    wq_entry_t           w_enq_entry;
    logic [WQ_DEPTH-1:0] w_match;
    logic [DATA_W-1:0]   w_byp_data;
    logic [DATA_W-1:0]   w_rsp_data;
    logic                w_enq;
    logic                w_rd_x0;
    logic                w_hazard;
    logic                w_rd_ready;
    logic                w_rd_acc;
    logic                w_rd_port;
    logic                w_rd_byp;
    logic                w_wr_gnt;
    logic                r_rsp_valid;
    logic                r_rsp_zero;
    logic                r_rsp_byp;
    logic [DATA_W-1:0]   r_byp_data;

    assign w_rd_x0     = (bus.rd_req_addr == REG_X0);
    assign w_hazard    = !w_rd_x0 && (|w_match);
    // x0 writes are accepted but never reach the queue.
    assign w_enq       = reset && bus.wr_req_valid && !w_full && (bus.wr_req_addr != REG_X0);
    assign w_enq_entry = '{addr: bus.wr_req_addr, data: bus.wr_req_data};
    assign w_rd_acc    = bus.rd_req_valid && w_rd_ready;

    regfile_wr_fifo #(
        .WQ_DEPTH (WQ_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_enq       (w_enq),
        .i_enq_entry (w_enq_entry),
        .i_deq       (w_wr_gnt),
        .i_q_addr    (bus.rd_req_addr),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head),
        .o_match     (w_match),
        .o_byp_data  (w_byp_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= READ_PRI;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Grant arbitration; everything stays idle (read x0) while reset is asserted.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = '0;
        w_rd_ready   = 1'b0;
        w_rd_port    = 1'b0;
        w_rd_byp     = 1'b0;
        w_wr_gnt     = 1'b0;
        if (reset) begin
            case (r_state)
                READ_PRI: begin
                    w_rd_ready = !w_hazard || BYPASS_EN;
                    w_rd_port  = bus.rd_req_valid && !w_rd_x0 && !w_hazard;
                    w_rd_byp   = bus.rd_req_valid && w_hazard && BYPASS_EN;
                    w_wr_gnt   = !w_empty && !w_rd_port;
                    if (w_rd_port && !w_empty) begin
                        w_starve_nxt = r_starve + STARVE_W'(1);
                    end
                    if ((w_starve_nxt == STARVE_W'(STARVE_MAX)) || (w_full && !w_wr_gnt)) begin
                        w_state_nxt = FORCE_WR;
                    end
                end
                FORCE_WR: begin
                    w_wr_gnt    = !w_empty;
                    w_state_nxt = READ_PRI;
                end
                default: begin
                    w_state_nxt = READ_PRI;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_byp   <= 1'b0;
            r_byp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rd_acc;
            r_rsp_zero  <= w_rd_acc && w_rd_x0;
            r_rsp_byp   <= w_rd_byp;
            if (w_rd_byp) begin
                r_byp_data <= w_byp_data;
            end
        end
    end

    always_comb begin
        w_rsp_data = '0;
        if (r_rsp_valid && !r_rsp_zero) begin
            w_rsp_data = r_rsp_byp ? r_byp_data : bus.rf_read_value;
        end
    end

    assign bus.rd_req_ready  = w_rd_ready;
    assign bus.wr_req_ready  = !w_full;
    assign bus.rd_rsp_valid  = r_rsp_valid;
    assign bus.rd_rsp_data   = w_rsp_data;
    assign bus.rf_r_or_w     = !w_wr_gnt;
    assign bus.rf_read_addr  = w_rd_port ? bus.rd_req_addr : REG_X0;
    assign bus.rf_write_addr = w_wr_gnt ? w_head.addr : REG_X0;
    assign bus.rf_write_val  = w_wr_gnt ? w_head.data : DATA_W'(0);

endmodule
